// File: rtl/power_pkg.sv
// Shared constants and FSM encoding for the power-pipe scheduler.
package power_pkg;
  localparam int PW_LATENCY_DEF = 3;
  localparam int RESULT_W       = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last granted index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic          found;
  logic          hit;
  logic [IW-1:0] idx;

  // Walk the requesters in rotated order and keep the first hit only
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    found = 1'b0;
    hit   = 1'b0;
    idx   = {IW{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx        = IW'((int'(ptr) + i) % NUM_REQ);
      hit        = req[idx] & ~found;
      grant[idx] = grant[idx] | hit;
      found      = found | hit;
    end
  end
endmodule

// File: rtl/power_sched.sv
// Schedules NUM_REQ requesters onto one shared power pipe and routes each
// result back to its owner using a tag pipe that tracks the pipe latency.
module power_sched
  import power_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int PW_LATENCY = PW_LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_pw_valid,
  output logic [DATA_WIDTH-1:0]         o_pw_data,
  input  logic                          i_pw_valid,
  input  logic [RESULT_W-1:0]           i_pw_data,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [RESULT_W-1:0]           o_rsp_data,
  output logic                          o_busy,
  output logic                          o_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(PW_LATENCY + 3);
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

  state_t                         state;
  logic [IW-1:0]                  rr_ptr;
  logic [IW-1:0]                  grant_idx;
  logic [IW-1:0]                  pw_idx;
  logic [NUM_REQ-1:0]             arb_req;
  logic [NUM_REQ-1:0]             grant;
  logic                           xfer;
  logic [PW_LATENCY-1:0]          tag_v;
  logic [PW_LATENCY-1:0][IW-1:0]  tag_idx;
  logic                           tag_out_v;
  logic [IW-1:0]                  tag_out_idx;
  logic                           rsp_fire;
  logic [CW-1:0]                  inflight;

  // New grants only while running with the enable still high
  assign arb_req = i_req_valid & {NUM_REQ{(state == ST_RUN) && i_enable}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign o_req_ready = grant;
  assign xfer        = |grant;
  assign tag_out_v   = tag_v[PW_LATENCY-1];
  assign tag_out_idx = tag_idx[PW_LATENCY-1];
  assign rsp_fire    = i_pw_valid & tag_out_v;

  // One-hot grant to binary index
  always_comb begin
    grant_idx = {IW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_idx = grant_idx | (grant[k] ? IW'(k) : {IW{1'b0}});
    end
  end

  // Scheduler FSM; busy is registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      o_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_enable) begin
            state  <= ST_RUN;
            o_busy <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight == {CW{1'b0}}) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Issue stage: register the granted operand toward the pipe and move the pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_pw_valid <= 1'b0;
      o_pw_data  <= {DATA_WIDTH{1'b0}};
      pw_idx     <= {IW{1'b0}};
      rr_ptr     <= PTR_RST;
    end else begin
      o_pw_valid <= xfer;
      if (xfer) begin
        o_pw_data <= i_req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        pw_idx    <= grant_idx;
        rr_ptr    <= grant_idx;
      end
    end
  end

  // Tag pipe mirrors the power pipe so the owner is known when the result exits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v   <= {PW_LATENCY{1'b0}};
      tag_idx <= '0;
    end else begin
      tag_v[0]   <= o_pw_valid;
      tag_idx[0] <= pw_idx;
      for (int s = 1; s < PW_LATENCY; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  // Response routing, sticky protocol error and in-flight accounting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rsp_valid <= {NUM_REQ{1'b0}};
      o_rsp_data  <= {RESULT_W{1'b0}};
      o_err       <= 1'b0;
      inflight    <= {CW{1'b0}};
    end else begin
      if (rsp_fire) begin
        o_rsp_valid <= NUM_REQ'(1) << tag_out_idx;
        o_rsp_data  <= i_pw_data;
      end else begin
        o_rsp_valid <= {NUM_REQ{1'b0}};
      end
      if (i_pw_valid != tag_out_v) begin
        o_err <= 1'b1;
      end
      // A slot retires whenever its tag exits, whether answered or dropped
      case ({xfer, tag_out_v})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_power_sched.sv
// Bench for power_sched: a cycle-level model built from the scheduling rules,
// a bench-side power pipe (result = operand cubed), and directed scenarios.
module tb_power_sched;
  localparam int PW_LATENCY = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_enable;
  logic [3:0]   i_req_valid;
  logic [127:0] i_req_data;
  logic [3:0]   o_req_ready;
  logic         o_pw_valid;
  logic [31:0]  o_pw_data;
  logic         i_pw_valid;
  logic [63:0]  i_pw_data;
  logic [3:0]   o_rsp_valid;
  logic [63:0]  o_rsp_data;
  logic         o_busy;
  logic         o_err;

  int errors = 0;
  int checks = 0;

  power_sched dut (
    .clk         (clk),
    .reset       (reset),
    .i_enable    (i_enable),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_pw_valid  (o_pw_valid),
    .o_pw_data   (o_pw_data),
    .i_pw_valid  (i_pw_valid),
    .i_pw_data   (i_pw_data),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) begin
      if (v == (4'b0001 << i)) r = i;
    end
    return r;
  endfunction

  function automatic logic [63:0] cube(input logic [31:0] x);
    logic [63:0] y = {32'b0, x};
    return y * y * y;
  endfunction

  // ---------------- behavioural model ----------------
  int          m_mode = 0;   // 0 idle, 1 run, 2 drain
  int          m_last = 3;
  int          m_cyc  = 0;
  int          slot[int];    // cycle the result is due -> owning requester
  int          mp, mj;
  logic [3:0]  mg;
  bit          mh;
  logic        e_pw_valid = 1'b0;
  logic [31:0] e_pw_data  = 32'h0;
  logic [3:0]  e_rsp_valid = 4'h0;
  logic [63:0] e_rsp_data  = 64'h0;
  logic        e_err  = 1'b0;
  logic        e_busy = 1'b0;

  function automatic logic [3:0] ready_fn();
    logic [3:0] r = 4'b0;
    if (m_mode == 1 && i_enable) begin
      for (int i = 1; i <= 4 && r == 4'b0; i++) begin
        if (i_req_valid[(m_last + i) % 4]) r[(m_last + i) % 4] = 1'b1;
      end
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_mode = 0; m_last = 3; slot.delete();
        e_pw_valid = 1'b0; e_pw_data = 32'h0; e_rsp_valid = 4'h0; e_rsp_data = 64'h0;
        e_err = 1'b0; e_busy = 1'b0;
      end else begin
        mp = slot.num();
        mg = ready_fn();
        mh = slot.exists(m_cyc);
        if (i_pw_valid && mh) begin
          e_rsp_valid = 4'b0001 << slot[m_cyc];
          e_rsp_data  = i_pw_data;
        end else begin
          e_rsp_valid = 4'b0;
        end
        if (i_pw_valid != mh) e_err = 1'b1;
        if (mh) slot.delete(m_cyc);
        mj = idx_of(mg);
        if (mj >= 0) begin
          e_pw_valid = 1'b1;
          e_pw_data  = i_req_data[mj*32 +: 32];
          slot[m_cyc + PW_LATENCY + 1] = mj;
          m_last = mj;
        end else begin
          e_pw_valid = 1'b0;
        end
        case (m_mode)
          0: if (i_enable) m_mode = 1;
          1: if (!i_enable) m_mode = 2;
          2: if (mp == 0) m_mode = 0;
          default: m_mode = 0;
        endcase
        e_busy = (m_mode != 0);
        m_cyc++;
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        check("ready", {60'b0, o_req_ready}, {60'b0, ready_fn()});
        check("pw_valid", {63'b0, o_pw_valid}, {63'b0, e_pw_valid});
        if (e_pw_valid) check("pw_data", {32'b0, o_pw_data}, {32'b0, e_pw_data});
        check("rsp_valid", {60'b0, o_rsp_valid}, {60'b0, e_rsp_valid});
        if (e_rsp_valid != 4'b0) check("rsp_data", o_rsp_data, e_rsp_data);
        check("err", {63'b0, o_err}, {63'b0, e_err});
        check("busy", {63'b0, o_busy}, {63'b0, e_busy});
      end
    end
  end

  // ---------------- stimulus with bench-side pipe ----------------
  logic        q_v [3];
  logic [63:0] q_d [3];
  logic        inj;
  logic [63:0] inj_d;
  logic [3:0]  s_ready, s_rsp_v;
  logic [63:0] s_rsp_d;
  logic        s_busy, s_err;

  task automatic step();
    logic        pv;
    logic [31:0] pd;
    @(negedge clk);
    s_ready = o_req_ready; s_rsp_v = o_rsp_valid; s_rsp_d = o_rsp_data;
    s_busy  = o_busy;      s_err   = o_err;
    pv = o_pw_valid; pd = o_pw_data;
    @(posedge clk);
    #1;
    q_v[2] = q_v[1]; q_d[2] = q_d[1];
    q_v[1] = q_v[0]; q_d[1] = q_d[0];
    q_v[0] = pv;     q_d[0] = cube(pd);
    i_pw_valid = q_v[2] | inj;
    i_pw_data  = inj ? inj_d : q_d[2];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, bad, nrsp, last_rsp, fall;
    int order [8];
    reset = 1'b1; i_enable = 1'b0; i_req_valid = 4'b0; i_req_data = 128'b0;
    i_pw_valid = 1'b0; i_pw_data = 64'b0; inj = 1'b0; inj_d = 64'b0;
    for (int i = 0; i < 3; i++) begin q_v[i] = 1'b0; q_d[i] = 64'b0; end
    step(); step();
    check("rst_ready", {60'b0, s_ready}, 64'h0);
    check("rst_rsp_v", {60'b0, s_rsp_v}, 64'h0);
    check("rst_busy_err", {62'b0, s_busy, s_err}, 64'h0);
    check("rst_pw", {31'b0, o_pw_valid, o_pw_data}, 64'h0);
    reset = 1'b0;

    // Single request from requester 2
    i_enable = 1'b1; step();
    i_req_valid = 4'b0100; i_req_data[64 +: 32] = 32'h5; step();
    check("t1_grant", {60'b0, s_ready}, 64'h4);
    i_req_valid = 4'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (s_rsp_v != 4'b0) lat = k;
    end
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_rsp_valid", {60'b0, s_rsp_v}, 64'h4);
    check("t1_rsp_data", s_rsp_d, 64'h7D);
    step(); step();

    // Fairness with all four requesting
    reset = 1'b1; #2; reset = 1'b0;
    i_enable = 1'b1; step();
    i_req_valid = 4'hF;
    for (int k = 0; k < 4; k++) i_req_data[k*32 +: 32] = 32'(16 + k);
    for (int i = 0; i < 8; i++) begin step(); order[i] = idx_of(s_ready); end
    i_req_valid = 4'b0;
    for (int i = 0; i < 8; i++) check("fair_order", 64'(order[i]), 64'(i % 4));
    for (int i = 0; i < 8; i++) step();

    // Drain with three results in flight
    i_req_valid = 4'b0111;
    step(); step(); step();
    i_enable = 1'b0; i_req_valid = 4'hF;
    bad = 0; nrsp = 0; last_rsp = 0; fall = 0;
    for (int k = 1; k <= 30 && fall == 0; k++) begin
      step();
      if (s_ready != 4'b0) bad++;
      if (s_rsp_v != 4'b0) begin nrsp++; last_rsp = k; end
      if (!s_busy) fall = k;
    end
    i_req_valid = 4'b0;
    check("drain_no_grant", 64'(bad), 64'd0);
    check("drain_rsp_count", 64'(nrsp), 64'd3);
    check("drain_busy_fall", 64'(fall - last_rsp), 64'd1);

    // Pipe result with no tag
    inj = 1'b1; inj_d = 64'hDEAD; step();
    inj = 1'b0; step(); step();
    check("perr_err", {63'b0, s_err}, 64'h1);
    check("perr_no_rsp", {60'b0, s_rsp_v}, 64'h0);
    nrsp = 0;
    for (int k = 0; k < 5; k++) begin step(); if (s_rsp_v != 4'b0) nrsp++; end
    check("perr_sticky", {63'b0, s_err}, 64'h1);
    check("perr_no_rsp_later", 64'(nrsp), 64'd0);

    // Reset pulse with two requests in flight
    reset = 1'b1; #2; reset = 1'b0;
    i_enable = 1'b1; step();
    i_req_valid = 4'b0011; step(); step();
    i_req_valid = 4'hF;
    reset = 1'b1; #1;
    check("mrst_ready", {60'b0, o_req_ready}, 64'h0);
    check("mrst_pw", {31'b0, o_pw_valid, o_pw_data}, 64'h0);
    check("mrst_rsp", {60'b0, o_rsp_valid}, 64'h0);
    check("mrst_rsp_data", o_rsp_data, 64'h0);
    check("mrst_busy_err", {62'b0, o_busy, o_err}, 64'h0);
    #1; reset = 1'b0; i_enable = 1'b0; i_req_valid = 4'b0;
    nrsp = 0;
    for (int k = 0; k < 12; k++) begin step(); if (s_rsp_v != 4'b0) nrsp++; end
    check("mrst_no_stale_rsp", 64'(nrsp), 64'd0);
    check("mrst_orphan_err", {63'b0, s_err}, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
